// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer that shares one combinational ALU
// between two requesters. The winner's opcode and operands are registered
// toward the ALU. After a programmable settle time the result and overflow
// are captured, and a one-cycle done pulse goes back to the winner.
// Per-requester completion counters are kept for LED/HEX display.
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [OPW-1:0]   op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_ovf,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             busy,
  output logic             owner,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // The settle counter holds 0..15 extra EXEC cycles.
  localparam int WAIT_W = 4;
  localparam logic [WAIT_W-1:0] LAT_LOAD = WAIT_W'(ALU_LAT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OPW-1:0]     alu_op_q, alu_op_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               owner_q, owner_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;

  logic grant_vld;
  logic grant_sel;

  // Pick a winner: a lone request wins outright, a tie goes to the requester that did not own the last grant.
  always_comb begin
    grant_vld = req0 | req1;
    if (req0 && req1) begin
      grant_sel = ~owner_q;
    end else begin
      grant_sel = req1;
    end
  end

  // Next-state logic: grant leaves IDLE, the settle count expires EXEC, DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (wait_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch operands at grant, count down the settle time, then capture and bump the owner's counter.
  always_comb begin
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    owner_d  = owner_q;
    wait_d   = wait_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    if (state_q == ST_IDLE && grant_vld) begin
      owner_d = grant_sel;
      wait_d  = LAT_LOAD;
      if (grant_sel) begin
        alu_op_d = op1;
        alu_a_d  = a1;
        alu_b_d  = b1;
      end else begin
        alu_op_d = op0;
        alu_a_d  = a0;
        alu_b_d  = b0;
      end
    end else if (state_q == ST_EXEC) begin
      if (wait_q != '0) begin
        wait_d = wait_q - WAIT_W'(1);
      end else begin
        res_d = alu_res;
        ovf_d = alu_ovf;
        if (owner_q) begin
          cnt1_d = cnt1_q + CNT_W'(1);
        end else begin
          cnt0_d = cnt0_q + CNT_W'(1);
        end
      end
    end
  end

  // Outputs decoded from the state: busy through EXEC and DONE, done only to the owner in DONE.
  always_comb begin
    busy  = (state_q != ST_IDLE);
    done0 = (state_q == ST_DONE) && !owner_q;
    done1 = (state_q == ST_DONE) && owner_q;
  end

  // State register; owner resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; an aborted operation leaves no trace after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      owner_q  <= 1'b1;
      wait_q   <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      owner_q  <= owner_d;
      wait_q   <= wait_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign alu_op = alu_op_q;
  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign res    = res_q;
  assign ovf    = ovf_q;
  assign owner  = owner_q;
  assign cnt0   = cnt0_q;
  assign cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: two instances (zero and three extra settle
// cycles) share the requester inputs; each has its own ALU model.
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;

  logic [2:0] l0AluOp, l3AluOp;
  logic [7:0] l0AluA, l0AluB, l3AluA, l3AluB;
  logic [7:0] l0AluRes, l3AluRes;
  logic       l0AluOvf, l3AluOvf;
  logic       l0Done0, l0Done1, l3Done0, l3Done1;
  logic [7:0] l0Res, l3Res;
  logic       l0Ovf, l3Ovf, l0Busy, l3Busy, l0Owner, l3Owner;
  logic [7:0] l0Cnt0, l0Cnt1, l3Cnt0, l3Cnt1;

  int compareCount = 0;
  int failCount    = 0;
  int monViol      = 0;
  int l0Done1Count = 0;

  // Reference ALU: 000 add, 001 sub, 010 dec, 011 inc, 100 and, 101 or, 110 not, 111 zero
  function automatic logic [8:0] aluModel(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       v;
    r = 8'h00;
    v = 1'b0;
    case (op)
      3'b000: begin r = a + b;     v = (a[7] == b[7]) && (r[7] != a[7]); end
      3'b001: begin r = a - b;     v = (a[7] != b[7]) && (r[7] != a[7]); end
      3'b010: begin r = a - 8'h01; v = (a == 8'h80); end
      3'b011: begin r = a + 8'h01; v = (a == 8'h7F); end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = ~a;
      default: r = 8'h00;
    endcase
    return {v, r};
  endfunction

  assign {l0AluOvf, l0AluRes} = aluModel(l0AluOp, l0AluA, l0AluB);
  assign {l3AluOvf, l3AluRes} = aluModel(l3AluOp, l3AluA, l3AluB);

  alu_arbiter #(.WIDTH(8), .OPW(3), .ALU_LAT(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .alu_op(l0AluOp), .alu_a(l0AluA), .alu_b(l0AluB),
    .alu_res(l0AluRes), .alu_ovf(l0AluOvf),
    .done0(l0Done0), .done1(l0Done1), .res(l0Res), .ovf(l0Ovf),
    .busy(l0Busy), .owner(l0Owner), .cnt0(l0Cnt0), .cnt1(l0Cnt1)
  );

  alu_arbiter #(.WIDTH(8), .OPW(3), .ALU_LAT(3), .CNT_W(8)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .alu_op(l3AluOp), .alu_a(l3AluA), .alu_b(l3AluB),
    .alu_res(l3AluRes), .alu_ovf(l3AluOvf),
    .done0(l3Done0), .done1(l3Done1), .res(l3Res), .ovf(l3Ovf),
    .busy(l3Busy), .owner(l3Owner), .cnt0(l3Cnt0), .cnt1(l3Cnt1)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watch both instances for two dones at once or a done while not busy; count u0 done1 pulses.
  always @(negedge clk) begin
    if ((l0Done0 && l0Done1) || (l3Done0 && l3Done1) ||
        ((l0Done0 || l0Done1) && !l0Busy) || ((l3Done0 || l3Done1) && !l3Busy)) begin
      monViol++;
    end
    if (l0Done1) begin
      l0Done1Count++;
    end
  end

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive both requester interfaces.
  task automatic applyStimulus(input logic r0, input logic [2:0] o0, input logic [7:0] x0, input logic [7:0] y0,
                               input logic r1, input logic [2:0] o1, input logic [7:0] x1, input logic [7:0] y1);
    req0 = r0; op0 = o0; a0 = x0; b0 = y0;
    req1 = r1; op1 = o1; a1 = x1; b1 = y1;
  endtask

  // Reset both instances for two cycles, releasing on a falling edge.
  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait on falling edges for a done pulse from the chosen instance; who stays -1 if the bound runs out.
  task automatic waitDone(input bit useLat3, input int bound, output int cycles, output int who);
    logic d0, d1;
    cycles = 0;
    who    = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      cycles++;
      d0 = useLat3 ? l3Done0 : l0Done0;
      d1 = useLat3 ? l3Done1 : l0Done1;
      if (d0) begin
        who = 0;
        break;
      end
      if (d1) begin
        who = 1;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int who;
    int base1;

    rst_n = 1'b0;
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_owner", 32'(l0Owner), 32'h1);
    checkOutput("rst_busy", 32'(l0Busy), 32'h0);
    checkOutput("rst_res", 32'(l0Res), 32'h0);
    checkOutput("rst_ovf", 32'(l0Ovf), 32'h0);
    checkOutput("rst_alu_op", 32'(l0AluOp), 32'h0);
    checkOutput("rst_alu_a", 32'(l0AluA), 32'h0);
    checkOutput("rst_cnt", 32'({l0Cnt1, l0Cnt0}), 32'h0);
    checkOutput("rst_done", 32'({l0Done1, l0Done0}), 32'h0);
    rst_n = 1'b1;

    // Single request: FF + FF
    $display("[TB] single request");
    base1 = l0Done1Count;
    applyStimulus(1'b1, 3'b000, 8'hFF, 8'hFF, 1'b0, 3'b000, 8'h00, 8'h00);
    waitDone(1'b0, 20, cyc, who);
    checkOutput("single_who", 32'(who), 32'h0);
    checkOutput("single_latency", 32'(cyc), 32'd2);
    checkOutput("single_res", 32'(l0Res), 32'hFE);
    checkOutput("single_ovf", 32'(l0Ovf), 32'h0);
    checkOutput("single_cnt0", 32'(l0Cnt0), 32'h1);
    checkOutput("single_owner", 32'(l0Owner), 32'h0);
    applyStimulus(1'b0, 3'b000, 8'hFF, 8'hFF, 1'b0, 3'b000, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("single_idle_busy", 32'(l0Busy), 32'h0);
    checkOutput("single_no_done1", 32'(l0Done1Count - base1), 32'h0);

    // Simultaneous requests: requester 0 first, then 10 - 03
    $display("[TB] simultaneous requests");
    doReset();
    applyStimulus(1'b1, 3'b000, 8'hFF, 8'hFF, 1'b1, 3'b001, 8'h10, 8'h03);
    waitDone(1'b0, 20, cyc, who);
    checkOutput("tie_first_who", 32'(who), 32'h0);
    checkOutput("tie_first_res", 32'(l0Res), 32'hFE);
    applyStimulus(1'b0, 3'b000, 8'hFF, 8'hFF, 1'b1, 3'b001, 8'h10, 8'h03);
    waitDone(1'b0, 20, cyc, who);
    checkOutput("tie_second_who", 32'(who), 32'h1);
    checkOutput("tie_second_cycles", 32'(cyc), 32'd3);
    checkOutput("tie_second_res", 32'(l0Res), 32'h0D);
    checkOutput("tie_second_ovf", 32'(l0Ovf), 32'h0);
    checkOutput("tie_owner", 32'(l0Owner), 32'h1);
    checkOutput("tie_cnt0", 32'(l0Cnt0), 32'h1);
    checkOutput("tie_cnt1", 32'(l0Cnt1), 32'h1);
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00);

    // Fairness: both held for six operations, 01+02 and 50|0A
    $display("[TB] fairness");
    doReset();
    applyStimulus(1'b1, 3'b000, 8'h01, 8'h02, 1'b1, 3'b101, 8'h50, 8'h0A);
    for (int i = 0; i < 6; i++) begin
      waitDone(1'b0, 20, cyc, who);
      checkOutput("fair_grant", 32'(who), 32'(i % 2));
      checkOutput("fair_res", 32'(l0Res), (i % 2 == 1) ? 32'h5A : 32'h03);
    end
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("fair_cnt0", 32'(l0Cnt0), 32'd3);
    checkOutput("fair_cnt1", 32'(l0Cnt1), 32'd3);

    // Latency: three extra settle cycles, 7F + 1 overflows
    $display("[TB] latency");
    doReset();
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b011, 8'h7F, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("lat_alu_a", 32'(l3AluA), 32'h7F);
      checkOutput("lat_busy", 32'(l3Busy), 32'h1);
      checkOutput("lat_done_early", 32'(l3Done1), 32'h0);
    end
    @(negedge clk);
    checkOutput("lat_done1", 32'(l3Done1), 32'h1);
    checkOutput("lat_res", 32'(l3Res), 32'h80);
    checkOutput("lat_ovf", 32'(l3Ovf), 32'h1);
    checkOutput("lat_cnt1", 32'(l3Cnt1), 32'h1);
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00);

    // Operand change after grant: 0F & 3C with a0 switched to F0
    $display("[TB] operand change after grant");
    doReset();
    applyStimulus(1'b1, 3'b100, 8'h0F, 8'h3C, 1'b0, 3'b000, 8'h00, 8'h00);
    @(negedge clk);
    applyStimulus(1'b1, 3'b100, 8'hF0, 8'h3C, 1'b0, 3'b000, 8'h00, 8'h00);
    waitDone(1'b0, 20, cyc, who);
    checkOutput("latch_l0_who", 32'(who), 32'h0);
    checkOutput("latch_l0_res", 32'(l0Res), 32'h0C);
    applyStimulus(1'b0, 3'b100, 8'hF0, 8'h3C, 1'b0, 3'b000, 8'h00, 8'h00);
    waitDone(1'b1, 20, cyc, who);
    checkOutput("latch_l3_who", 32'(who), 32'h0);
    checkOutput("latch_l3_res", 32'(l3Res), 32'h0C);
    checkOutput("latch_l3_alu_a", 32'(l3AluA), 32'h0F);

    // Reset in the middle of EXEC
    $display("[TB] reset mid-EXEC");
    doReset();
    applyStimulus(1'b1, 3'b000, 8'h05, 8'h06, 1'b0, 3'b000, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("abort_busy_before", 32'(l3Busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b1, 3'b000, 8'h05, 8'h06, 1'b1, 3'b001, 8'h20, 8'h01);
    #1;
    checkOutput("abort_busy", 32'(l3Busy), 32'h0);
    checkOutput("abort_res", 32'(l3Res), 32'h0);
    checkOutput("abort_alu_a", 32'(l3AluA), 32'h0);
    checkOutput("abort_owner", 32'(l3Owner), 32'h1);
    checkOutput("abort_l0_cnt0", 32'(l0Cnt0), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'({l3Done1, l3Done0, l0Done1, l0Done0}), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_tie_owner", 32'(l3Owner), 32'h0);
    checkOutput("abort_tie_alu_a", 32'(l3AluA), 32'h05);
    waitDone(1'b1, 20, cyc, who);
    checkOutput("abort_after_who", 32'(who), 32'h0);
    checkOutput("abort_after_res", 32'(l3Res), 32'h0B);
    applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00);
    repeat (8) @(negedge clk);

    checkOutput("done_exclusive", 32'(monViol), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
